// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle for axil_slave_regfile; the master drives requests and
// response-ready, the slave drives address/data-ready and the B/R responses.
interface axil_slave_regfile_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
   logic [2:0]              s_axi_awprot;
   logic                    s_axi_awvalid;
   logic                    s_axi_awready;
   logic [DATA_WIDTH-1:0]   s_axi_wdata;
   logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
   logic                    s_axi_wvalid;
   logic                    s_axi_wready;
   logic [1:0]              s_axi_bresp;
   logic                    s_axi_bvalid;
   logic                    s_axi_bready;
   logic [ADDR_WIDTH-1:0]   s_axi_araddr;
   logic [2:0]              s_axi_arprot;
   logic                    s_axi_arvalid;
   logic                    s_axi_arready;
   logic [DATA_WIDTH-1:0]   s_axi_rdata;
   logic [1:0]              s_axi_rresp;
   logic                    s_axi_rvalid;
   logic                    s_axi_rready;

   modport master (
      output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      output s_axi_rready,
      input  s_axi_awready, s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport slave (
      input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
      input  s_axi_rready,
      output s_axi_awready, s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite register file (NUM_REGS x 32b); B/R valid one cycle after the completing handshake, new AW/W/AR
// stall while the matching response waits. Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_slave_regfile #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   axil_slave_regfile_if.slave     s_axi,
   output logic [32*NUM_REGS-1:0]  reg_q
);
   localparam int         IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
   localparam int         STRB_W      = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                          rst_done_q, rst_done_d;
   logic                          aw_held_q, aw_held_d;
   logic [IDX_W-1:0]              aw_idx_q, aw_idx_d;
   logic                          w_held_q, w_held_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]             wstrb_q, wstrb_d;
   logic                          bvalid_q, bvalid_d;
   logic [1:0]                    bresp_q, bresp_d;
   logic                          rvalid_q, rvalid_d;
   logic [1:0]                    rresp_q, rresp_d;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [NUM_REGS-1:0][31:0]     regs_q, regs_d;

   logic                          awready, wready, arready;
   logic                          aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]              wr_idx, rd_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]             wr_strb;
   logic                          unused_bits;

   assign awready = rst_done_q & ~aw_held_q & ~bvalid_q;
   assign wready  = rst_done_q & ~w_held_q & ~bvalid_q;
   assign arready = rst_done_q & ~rvalid_q;

   assign aw_hs = s_axi.s_axi_awvalid & awready;
   assign w_hs  = s_axi.s_axi_wvalid & wready;
   assign ar_hs = s_axi.s_axi_arvalid & arready;

   // A channel is usable for commit if it is already held or handshaking right now.
   assign wr_idx  = aw_held_q ? aw_idx_q : s_axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_data = w_held_q ? wdata_q : s_axi.s_axi_wdata;
   assign wr_strb = w_held_q ? wstrb_q : s_axi.s_axi_wstrb;
   assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
   assign rd_idx  = s_axi.s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

   always_comb begin
      rst_done_d = 1'b1;
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      regs_d     = regs_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = s_axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axi.s_axi_wdata;
         wstrb_d  = s_axi.s_axi_wstrb;
      end
      if (bvalid_q && s_axi.s_axi_bready) begin
         bvalid_d = 1'b0;
      end
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
`ifdef AXIL_SLVERR_EN
         bresp_d   = (32'(wr_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
`else
         bresp_d   = RESP_OKAY;
`endif
         // Out-of-range indices match no register, so they fall through as a drop.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                  end
               end
            end
         end
      end

      if (rvalid_q && s_axi.s_axi_rready) begin
         rvalid_d = 1'b0;
      end
      // Reads sample regs_q, so a same-cycle commit is not visible to this read.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
               rdata_d = regs_q[i];
            end
         end
`ifdef AXIL_SLVERR_EN
         rresp_d  = (32'(rd_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
`else
         rresp_d  = RESP_OKAY;
`endif
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rst_done_q <= 1'b0;
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         regs_q     <= '0;
      end else begin
         rst_done_q <= rst_done_d;
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         regs_q     <= regs_d;
      end
   end

   assign s_axi.s_axi_awready = awready;
   assign s_axi.s_axi_wready  = wready;
   assign s_axi.s_axi_arready = arready;
   assign s_axi.s_axi_bvalid  = bvalid_q;
   assign s_axi.s_axi_bresp   = bresp_q;
   assign s_axi.s_axi_rvalid  = rvalid_q;
   assign s_axi.s_axi_rresp   = rresp_q;
   assign s_axi.s_axi_rdata   = rdata_q;
   assign reg_q               = regs_q;

   assign unused_bits = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                          s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};
endmodule

// File: tb/tb_axil_slave_regfile.sv
// Bench for axil_slave_regfile: a 4-register and a 3-register instance share one stimulus stream;
// vector table, hand sequences for skew/backpressure/collision/reset, then random traffic vs. array model.
`timescale 1ns/1ps
module tb_axil_slave_regfile;
   logic ACLK;
   logic ARESETN;
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   axil_slave_regfile_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus4 ();
   axil_slave_regfile_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus3 ();
   logic [127:0] reg_q4;
   logic [95:0]  reg_q3;

   assign bus3.s_axi_awaddr  = bus4.s_axi_awaddr;
   assign bus3.s_axi_awprot  = bus4.s_axi_awprot;
   assign bus3.s_axi_awvalid = bus4.s_axi_awvalid;
   assign bus3.s_axi_wdata   = bus4.s_axi_wdata;
   assign bus3.s_axi_wstrb   = bus4.s_axi_wstrb;
   assign bus3.s_axi_wvalid  = bus4.s_axi_wvalid;
   assign bus3.s_axi_bready  = bus4.s_axi_bready;
   assign bus3.s_axi_araddr  = bus4.s_axi_araddr;
   assign bus3.s_axi_arprot  = bus4.s_axi_arprot;
   assign bus3.s_axi_arvalid = bus4.s_axi_arvalid;
   assign bus3.s_axi_rready  = bus4.s_axi_rready;

   axil_slave_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(4)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus4.slave), .reg_q(reg_q4));
   axil_slave_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
      .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus3.slave), .reg_q(reg_q3));

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m4 [4];
   logic [31:0] m3 [3];
   logic [1:0]  last_bresp4, last_bresp3, last_rresp4, last_rresp3;
   logic [31:0] last_rdata4, last_rdata3;

   typedef struct {
      bit          is_wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t vecs [11];

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(a) / 4;
      if (idx < 4) m4[idx] = merge(m4[idx], d, s);
      if (idx < 3) m3[idx] = merge(m3[idx], d, s);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) m4[i] = 32'h0;
      for (int i = 0; i < 3; i++) m3[i] = 32'h0;
   endfunction

   function automatic logic [1:0] exp_resp(input int idx, input int n);
`ifdef AXIL_SLVERR_EN
      return (idx < n) ? 2'b00 : 2'b10;
`else
      return (idx < n) ? 2'b00 : 2'b00;
`endif
   endfunction

   function automatic logic [31:0] exp_rd(input int idx, input int n);
      if (idx >= n) return 32'h0;
      return (n == 4) ? m4[idx] : m3[idx];
   endfunction

   function automatic logic [127:0] pack4();
      return {m4[3], m4[2], m4[1], m4[0]};
   endfunction

   function automatic logic [127:0] pack3();
      return {32'h0, m3[2], m3[1], m3[0]};
   endfunction

   task automatic wait_b(input int bdelay);
      int n;
      for (int i = 0; i < bdelay; i++) begin
         @(negedge ACLK);
         check("b_hold_bvalid", bus4.s_axi_bvalid, 1);
         check("b_hold_awready", bus4.s_axi_awready, 0);
         check("b_hold_wready", bus4.s_axi_wready, 0);
         @(posedge ACLK); #1;
      end
      bus4.s_axi_bready = 1'b1;
      n = 0;
      while (!bus4.s_axi_bvalid && n < 20) begin
         @(posedge ACLK); #1;
         n++;
      end
      check("bvalid_timeout", bus4.s_axi_bvalid, 1);
      last_bresp4 = bus4.s_axi_bresp;
      last_bresp3 = bus3.s_axi_bresp;
      @(posedge ACLK); #1;
      bus4.s_axi_bready = 1'b0;
      check("bvalid_clear", bus4.s_axi_bvalid, 0);
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int bdelay);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      bus4.s_axi_awaddr  = a;
      bus4.s_axi_wdata   = d;
      bus4.s_axi_wstrb   = s;
      bus4.s_axi_awvalid = 1'b1;
      bus4.s_axi_wvalid  = 1'b1;
      bus4.s_axi_bready  = 1'b0;
      while (!(aw_done && w_done) && n < 20) begin
         @(negedge ACLK);
         aw_hs = bus4.s_axi_awvalid && bus4.s_axi_awready;
         w_hs  = bus4.s_axi_wvalid && bus4.s_axi_wready;
         @(posedge ACLK); #1;
         if (aw_hs) begin aw_done = 1; bus4.s_axi_awvalid = 1'b0; end
         if (w_hs)  begin w_done = 1;  bus4.s_axi_wvalid  = 1'b0; end
         n++;
      end
      check("wr_handshake", aw_done && w_done, 1);
      check("b_latency", bus4.s_axi_bvalid, 1);
      model_write(a, d, s);
      wait_b(bdelay);
   endtask

   task automatic axi_read(input logic [3:0] a, input int rdelay);
      logic [31:0] e4;
      bit done, hs;
      int n;
      e4 = exp_rd(int'(a) / 4, 4);
      done = 0; n = 0;
      bus4.s_axi_araddr  = a;
      bus4.s_axi_arvalid = 1'b1;
      bus4.s_axi_rready  = 1'b0;
      while (!done && n < 20) begin
         @(negedge ACLK);
         hs = bus4.s_axi_arvalid && bus4.s_axi_arready;
         @(posedge ACLK); #1;
         if (hs) begin done = 1; bus4.s_axi_arvalid = 1'b0; end
         n++;
      end
      check("ar_handshake", done, 1);
      check("r_latency", bus4.s_axi_rvalid, 1);
      for (int i = 0; i < rdelay; i++) begin
         @(negedge ACLK);
         check("r_hold_rvalid", bus4.s_axi_rvalid, 1);
         check("r_hold_rdata", bus4.s_axi_rdata, e4);
         check("r_hold_arready", bus4.s_axi_arready, 0);
         @(posedge ACLK); #1;
      end
      bus4.s_axi_rready = 1'b1;
      @(negedge ACLK);
      last_rdata4 = bus4.s_axi_rdata;
      last_rresp4 = bus4.s_axi_rresp;
      last_rdata3 = bus3.s_axi_rdata;
      last_rresp3 = bus3.s_axi_rresp;
      @(posedge ACLK); #1;
      bus4.s_axi_rready = 1'b0;
      check("r_clear", bus4.s_axi_rvalid, 0);
   endtask

   initial begin
      logic [3:0]   ra, rs;
      logic [31:0]  rd, old, sdata;
      logic [127:0] q3_before;
      logic [1:0]   oor;
      int           rdl;

      vecs[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0, 2'b00};
      vecs[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0, 2'b00};
      vecs[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0, 2'b00};
      vecs[3]  = '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h0, 2'b00};
      vecs[4]  = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0001, 2'b00};
      vecs[5]  = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0002, 2'b00};
      vecs[6]  = '{1'b0, 4'h8, 32'h0, 4'h0, 32'h0000_0003, 2'b00};
      vecs[7]  = '{1'b0, 4'hC, 32'h0, 4'h0, 32'h0000_0004, 2'b00};
      vecs[8]  = '{1'b1, 4'h0, 32'hAABB_CCDD, 4'hF, 32'h0, 2'b00};
      vecs[9]  = '{1'b1, 4'h0, 32'h1122_3344, 4'h5, 32'h0, 2'b00};
      vecs[10] = '{1'b0, 4'h0, 32'h0, 4'h0, 32'hAA22_CC44, 2'b00};

`ifdef AXIL_SLVERR_EN
      oor = 2'b10;
`else
      oor = 2'b00;
`endif

      ARESETN = 1'b0;
      bus4.s_axi_awaddr = '0; bus4.s_axi_awprot = '0; bus4.s_axi_awvalid = 1'b0;
      bus4.s_axi_wdata = '0;  bus4.s_axi_wstrb = '0;  bus4.s_axi_wvalid = 1'b0;
      bus4.s_axi_bready = 1'b0;
      bus4.s_axi_araddr = '0; bus4.s_axi_arprot = '0; bus4.s_axi_arvalid = 1'b0;
      bus4.s_axi_rready = 1'b0;
      model_clear();

      repeat (2) @(posedge ACLK);
      #1;
      check("rst_reg_q4", reg_q4, 0);
      check("rst_bvalid", bus4.s_axi_bvalid, 0);
      check("rst_rvalid", bus4.s_axi_rvalid, 0);
      check("rst_awready", bus4.s_axi_awready, 0);
      check("rst_arready", bus4.s_axi_arready, 0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      #1;
      check("rel_awready_early", bus4.s_axi_awready, 0);
      @(posedge ACLK); #1;
      check("rel_awready", bus4.s_axi_awready, 1);
      check("rel_wready", bus4.s_axi_wready, 1);
      check("rel_arready", bus4.s_axi_arready, 1);

      // Sequential writes/readback and byte strobes
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0);
            check("tbl_bresp", last_bresp4, vecs[i].exp_resp);
         end else begin
            axi_read(vecs[i].addr, 0);
            check("tbl_rdata", last_rdata4, vecs[i].exp_rdata);
            check("tbl_rresp", last_rresp4, vecs[i].exp_resp);
         end
         if (i == 7) check("tbl_reg_q", reg_q4, 128'h00000004_00000003_00000002_00000001);
      end

      // Channel skew: o=0 W leads AW by 3 cycles, o=1 AW leads W
      for (int o = 0; o < 2; o++) begin
         sdata = (o == 0) ? 32'hCAFE_0002 : 32'h5555_0001;
         bus4.s_axi_awaddr = 4'h4;
         bus4.s_axi_wdata  = sdata;
         bus4.s_axi_wstrb  = 4'hF;
         if (o == 0) bus4.s_axi_wvalid = 1'b1; else bus4.s_axi_awvalid = 1'b1;
         @(negedge ACLK);
         check("skew_first_ready", (o == 0) ? bus4.s_axi_wready : bus4.s_axi_awready, 1);
         @(posedge ACLK); #1;
         bus4.s_axi_wvalid = 1'b0; bus4.s_axi_awvalid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            check("skew_held_ready", (o == 0) ? bus4.s_axi_wready : bus4.s_axi_awready, 0);
            check("skew_no_b", bus4.s_axi_bvalid, 0);
            @(posedge ACLK); #1;
         end
         if (o == 0) bus4.s_axi_awvalid = 1'b1; else bus4.s_axi_wvalid = 1'b1;
         @(negedge ACLK);
         check("skew_second_ready", (o == 0) ? bus4.s_axi_awready : bus4.s_axi_wready, 1);
         check("skew_b_before", bus4.s_axi_bvalid, 0);
         @(posedge ACLK); #1;
         bus4.s_axi_wvalid = 1'b0; bus4.s_axi_awvalid = 1'b0;
         check("skew_b_latency", bus4.s_axi_bvalid, 1);
         model_write(4'h4, sdata, 4'hF);
         wait_b(0);
         check("skew_bresp", last_bresp4, 2'b00);
         axi_read(4'h4, 0);
         check("skew_rdata", last_rdata4, sdata);
      end

      // Backpressure on B and R
      axi_write(4'h8, 32'h0BAD_F00D, 4'hF, 5);
      check("bp_bresp", last_bresp4, 2'b00);
      axi_read(4'h8, 5);
      check("bp_rdata", last_rdata4, 32'h0BAD_F00D);

      // Same-cycle commit and read of one register: read sees the old value
      old = m4[1];
      bus4.s_axi_awaddr = 4'h4; bus4.s_axi_wdata = 32'h7777_8888; bus4.s_axi_wstrb = 4'hF;
      bus4.s_axi_araddr = 4'h4;
      bus4.s_axi_awvalid = 1'b1; bus4.s_axi_wvalid = 1'b1; bus4.s_axi_arvalid = 1'b1;
      @(negedge ACLK);
      check("coll_readies", {bus4.s_axi_awready, bus4.s_axi_wready, bus4.s_axi_arready}, 3'b111);
      @(posedge ACLK); #1;
      bus4.s_axi_awvalid = 1'b0; bus4.s_axi_wvalid = 1'b0; bus4.s_axi_arvalid = 1'b0;
      check("coll_bvalid", bus4.s_axi_bvalid, 1);
      check("coll_rvalid", bus4.s_axi_rvalid, 1);
      check("coll_rdata_old", bus4.s_axi_rdata, old);
      model_write(4'h4, 32'h7777_8888, 4'hF);
      bus4.s_axi_bready = 1'b1; bus4.s_axi_rready = 1'b1;
      @(posedge ACLK); #1;
      bus4.s_axi_bready = 1'b0; bus4.s_axi_rready = 1'b0;
      check("coll_b_clear", bus4.s_axi_bvalid, 0);
      check("coll_reg_q", reg_q4, pack4());

      // Out-of-range on the 3-register instance
      q3_before = pack3();
      axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 0);
      check("oor_bresp", last_bresp3, oor);
      check("oor_reg_q3", reg_q3, q3_before);
      check("oor_inrange_bresp4", last_bresp4, 2'b00);
      axi_read(4'hC, 0);
      check("oor_rdata", last_rdata3, 0);
      check("oor_rresp", last_rresp3, oor);
      check("oor_inrange_rdata4", last_rdata4, 32'hDEAD_BEEF);

      // Reset with an AW held and no W
      bus4.s_axi_awaddr = 4'h8; bus4.s_axi_awvalid = 1'b1;
      @(negedge ACLK);
      check("mrst_aw_ready", bus4.s_axi_awready, 1);
      @(posedge ACLK); #1;
      bus4.s_axi_awvalid = 1'b0;
      @(negedge ACLK); #2;
      ARESETN = 1'b0;
      #1;
      model_clear();
      check("mrst_reg_q4", reg_q4, 0);
      check("mrst_reg_q3", reg_q3, 0);
      check("mrst_outs", {bus4.s_axi_bvalid, bus4.s_axi_rvalid, bus4.s_axi_bresp, bus4.s_axi_rresp}, 0);
      check("mrst_rdata", bus4.s_axi_rdata, 0);
      check("mrst_readies", {bus4.s_axi_awready, bus4.s_axi_wready, bus4.s_axi_arready}, 0);
      @(posedge ACLK); #3;
      ARESETN = 1'b1;
      @(negedge ACLK);
      check("mrst_ready_early", bus4.s_axi_awready, 0);
      @(posedge ACLK); #1;
      check("mrst_readies_back", {bus4.s_axi_awready, bus4.s_axi_wready, bus4.s_axi_arready}, 3'b111);
      bus4.s_axi_wdata = 32'h1234_5678; bus4.s_axi_wstrb = 4'hF; bus4.s_axi_wvalid = 1'b1;
      @(negedge ACLK);
      check("mrst_w_ready", bus4.s_axi_wready, 1);
      @(posedge ACLK); #1;
      bus4.s_axi_wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK);
         check("mrst_no_b", bus4.s_axi_bvalid, 0);
      end
      @(posedge ACLK); #1;
      bus4.s_axi_awaddr = 4'h0; bus4.s_axi_awvalid = 1'b1;
      @(negedge ACLK);
      @(posedge ACLK); #1;
      bus4.s_axi_awvalid = 1'b0;
      check("mrst_b_after_aw", bus4.s_axi_bvalid, 1);
      model_write(4'h0, 32'h1234_5678, 4'hF);
      wait_b(0);
      check("mrst_reg_q4_after", reg_q4, pack4());

      // Random traffic against the array model
      for (int k = 0; k < 60; k++) begin
         ra  = 4'($urandom_range(0, 15));
         rd  = $urandom;
         rs  = 4'($urandom_range(0, 15));
         rdl = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1) begin
            axi_write(ra, rd, rs, rdl);
            check("rand_bresp4", last_bresp4, exp_resp(int'(ra) / 4, 4));
            check("rand_bresp3", last_bresp3, exp_resp(int'(ra) / 4, 3));
            check("rand_reg_q4", reg_q4, pack4());
            check("rand_reg_q3", reg_q3, pack3());
         end else begin
            axi_read(ra, rdl);
            check("rand_rdata4", last_rdata4, exp_rd(int'(ra) / 4, 4));
            check("rand_rresp4", last_rresp4, exp_resp(int'(ra) / 4, 4));
            check("rand_rdata3", last_rdata3, exp_rd(int'(ra) / 4, 3));
            check("rand_rresp3", last_rresp3, exp_resp(int'(ra) / 4, 3));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
